// File: rtl/hex_result_sender.sv
// hex_result_sender: sends a result word to the UART TX byte interface as
// uppercase ASCII hex, most significant nibble first. Leading zero digits can
// be dropped, and CR LF can be appended. Each byte moves over valid/ready.
module hex_result_sender #(
  parameter int DATA_W        = 16,
  parameter bit SEND_CRLF     = 1'b1,
  parameter bit ZERO_SUPPRESS = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = $clog2(NIB + 1);
  localparam logic [CNT_W-1:0] NIB_CNT = CNT_W'(NIB);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIGIT  = 3'd1,
    S_CR     = 3'd2,
    S_LF     = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_lz;
  logic                w_found;
  logic [DATA_W-1:0]   w_shift_init;
  logic [CNT_W-1:0]    w_cnt_init;
  logic [3:0]          w_nib;
  logic                w_accept;
  logic                w_xfer;
  logic                w_last_digit;

  // FINISH also accepts START so messages can run back to back.
  assign w_accept     = i_start && ((r_state == S_IDLE) || (r_state == S_FINISH));
  assign w_xfer       = o_tx_valid && i_tx_ready;
  assign w_last_digit = (r_cnt == CNT_ONE);
  assign w_nib        = r_shift[DATA_W-1 -: 4];

  // Count leading zero nibbles of the incoming word. The lowest nibble is
  // never counted, so an all-zero word still sends one '0' digit.
  always_comb begin
    w_lz    = '0;
    w_found = 1'b0;
    for (int i = NIB - 1; i >= 1; i--) begin
      if (!w_found) begin
        if (i_data[4*i +: 4] == 4'h0) w_lz = w_lz + CNT_ONE;
        else                          w_found = 1'b1;
      end
    end
  end

  // Pre-align the word so the first digit to send sits in the top nibble.
  always_comb begin
    if (ZERO_SUPPRESS) begin
      w_shift_init = i_data << (4 * w_lz);
      w_cnt_init   = NIB_CNT - w_lz;
    end else begin
      w_shift_init = i_data;
      w_cnt_init   = NIB_CNT;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; every byte state advances only on a transfer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_DIGIT;
      S_DIGIT:  if (w_xfer && w_last_digit) w_next = SEND_CRLF ? S_CR : S_FINISH;
      S_CR:     if (w_xfer) w_next = S_LF;
      S_LF:     if (w_xfer) w_next = S_FINISH;
      S_FINISH: w_next = w_accept ? S_DIGIT : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Word capture on accept, shift and count down on each digit transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= w_shift_init;
      r_cnt   <= w_cnt_init;
    end else if ((r_state == S_DIGIT) && w_xfer) begin
      r_shift <= r_shift << 4;
      r_cnt   <= r_cnt - CNT_ONE;
    end
  end

  // Outputs decode from the state only, so they hold while the UART stalls
  // and fall to their reset values as soon as reset forces IDLE.
  always_comb begin
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_tx_valid = 1'b0;
    o_tx_data  = 8'h00;
    case (r_state)
      S_DIGIT: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                     : (8'h37 + {4'h0, w_nib});
      end
      S_CR: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h0D;
      end
      S_LF: begin
        o_busy     = 1'b1;
        o_tx_valid = 1'b1;
        o_tx_data  = 8'h0A;
      end
      S_FINISH: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hex_result_sender.sv
// Directed bench for hex_result_sender with three configurations: CR LF on,
// zero suppression on, and digits only. Expected bytes are queued when a
// message is started and popped as the DUT transfers them.
module tb_hex_result_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  // a: SEND_CRLF=1, ZERO_SUPPRESS=0
  logic        a_start = 0, a_busy, a_done, a_valid, a_ready = 1;
  logic [15:0] a_din = 0;
  logic [7:0]  a_data;
  // b: SEND_CRLF=1, ZERO_SUPPRESS=1
  logic        b_start = 0, b_busy, b_done, b_valid, b_ready = 1;
  logic [15:0] b_din = 0;
  logic [7:0]  b_data;
  // c: SEND_CRLF=0, ZERO_SUPPRESS=0
  logic        c_start = 0, c_busy, c_done, c_valid, c_ready = 1;
  logic [15:0] c_din = 0;
  logic [7:0]  c_data;

  hex_result_sender #(.DATA_W(16), .SEND_CRLF(1'b1), .ZERO_SUPPRESS(1'b0)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_data(a_din), .o_busy(a_busy),
    .o_done(a_done), .o_tx_data(a_data), .o_tx_valid(a_valid), .i_tx_ready(a_ready));
  hex_result_sender #(.DATA_W(16), .SEND_CRLF(1'b1), .ZERO_SUPPRESS(1'b1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_data(b_din), .o_busy(b_busy),
    .o_done(b_done), .o_tx_data(b_data), .o_tx_valid(b_valid), .i_tx_ready(b_ready));
  hex_result_sender #(.DATA_W(16), .SEND_CRLF(1'b0), .ZERO_SUPPRESS(1'b0)) u_c (
    .i_clk(clk), .i_rst(rst), .i_start(c_start), .i_data(c_din), .o_busy(c_busy),
    .o_done(c_done), .o_tx_data(c_data), .o_tx_valid(c_valid), .i_tx_ready(c_ready));

  int total = 0;
  int bad   = 0;
  logic [7:0] qa[$], qb[$], qc[$];
  int a_dones = 0, b_dones = 0, c_dones = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a byte transfers on the next rising edge when
  // valid and ready are both high, so sample them mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) begin
        if (qa.size() == 0) chk("a_unexp_byte", {24'h0, a_data}, 32'h100);
        else                chk("a_byte", {24'h0, a_data}, {24'h0, qa.pop_front()});
      end
      if (b_valid && b_ready) begin
        if (qb.size() == 0) chk("b_unexp_byte", {24'h0, b_data}, 32'h100);
        else                chk("b_byte", {24'h0, b_data}, {24'h0, qb.pop_front()});
      end
      if (c_valid && c_ready) begin
        if (qc.size() == 0) chk("c_unexp_byte", {24'h0, c_data}, 32'h100);
        else                chk("c_byte", {24'h0, c_data}, {24'h0, qc.pop_front()});
      end
      if (a_done) a_dones++;
      if (b_done) b_dones++;
      if (c_done) c_dones++;
    end
  end

  // Called in cycle 0 with START already high: drops START after one cycle
  // and checks DONE rises exactly exp_cyc cycles after START.
  task automatic wait_done_b(input string tag, input int exp_cyc);
    int n;
    for (n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) b_start = 0;
      if (b_done) break;
    end
    chk(tag, n, exp_cyc);
  endtask

  task automatic wait_done_a(input string tag, input int exp_cyc);
    int n;
    for (n = 1; n <= 30; n++) begin
      tick();
      if (n == 1) a_start = 0;
      if (a_done) break;
    end
    chk(tag, n, exp_cyc);
  endtask

  initial begin
    int d0;
    #1 rst = 1;
    #1;
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_data",  a_data, 8'h00);
    chk("rst_a_busy",  a_busy, 0);
    chk("rst_a_done",  a_done, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_c_valid", c_valid, 0);
    repeat (2) tick();
    rst = 0;
    repeat (2) tick();

    // Basic message with cycle-exact bytes and DONE.
    a_din = 16'h1A3F; a_start = 1;
    qa.push_back(8'h31); qa.push_back(8'h41); qa.push_back(8'h33);
    qa.push_back(8'h46); qa.push_back(8'h0D); qa.push_back(8'h0A);
    tick(); a_start = 0; a_din = 16'h5555;
    for (int c = 1; c <= 6; c++) begin
      chk("basic_valid", a_valid, 1);
      chk("basic_busy",  a_busy, 1);
      chk("basic_done",  a_done, 0);
      tick();
    end
    chk("basic_done7",  a_done, 1);
    chk("basic_busy7",  a_busy, 0);
    chk("basic_valid7", a_valid, 0);
    tick();
    chk("basic_done8",  a_done, 0);
    chk("basic_q_empty", qa.size(), 0);
    repeat (2) tick();

    // Backpressure on cycles 2-4.
    a_din = 16'h1A3F; a_start = 1;
    qa.push_back(8'h31); qa.push_back(8'h41); qa.push_back(8'h33);
    qa.push_back(8'h46); qa.push_back(8'h0D); qa.push_back(8'h0A);
    tick(); a_start = 0;
    chk("bp_first", a_data, 8'h31);
    tick();
    a_ready = 0;
    for (int c = 2; c <= 4; c++) begin
      chk("bp_hold_data",  a_data, 8'h41);
      chk("bp_hold_valid", a_valid, 1);
      tick();
    end
    a_ready = 1;
    for (int c = 5; c <= 9; c++) begin
      chk("bp_no_done", a_done, 0);
      tick();
    end
    chk("bp_done10", a_done, 1);
    chk("bp_q_empty", qa.size(), 0);
    repeat (2) tick();

    // Zero suppression.
    b_din = 16'h00A0; b_start = 1;
    qb.push_back(8'h41); qb.push_back(8'h30); qb.push_back(8'h0D); qb.push_back(8'h0A);
    wait_done_b("zs_00A0_done_cycle", 5);
    tick(); tick();
    b_din = 16'h0000; b_start = 1;
    qb.push_back(8'h30); qb.push_back(8'h0D); qb.push_back(8'h0A);
    wait_done_b("zs_0000_done_cycle", 4);
    chk("zs_q_empty", qb.size(), 0);
    repeat (2) tick();

    // START during a message is ignored.
    d0 = a_dones;
    a_din = 16'h1A3F; a_start = 1;
    qa.push_back(8'h31); qa.push_back(8'h41); qa.push_back(8'h33);
    qa.push_back(8'h46); qa.push_back(8'h0D); qa.push_back(8'h0A);
    tick(); a_start = 0;
    tick(); tick();
    a_start = 1; a_din = 16'hFFFF;
    tick(); a_start = 0;
    repeat (8) tick();
    chk("ign_one_done", a_dones - d0, 1);
    chk("ign_q_empty", qa.size(), 0);

    // Reset mid-message acts without a clock edge.
    a_din = 16'h1A3F; a_start = 1;
    qa.push_back(8'h31); qa.push_back(8'h41);
    tick(); a_start = 0;
    tick(); tick();
    #1 rst = 1;
    #1;
    chk("mrst_valid", a_valid, 0);
    chk("mrst_data",  a_data, 8'h00);
    chk("mrst_busy",  a_busy, 0);
    chk("mrst_done",  a_done, 0);
    chk("mrst_q_empty", qa.size(), 0);
    tick(); tick();
    rst = 0;
    d0 = a_dones;
    repeat (6) begin
      tick();
      chk("post_rst_idle", a_valid, 0);
    end
    chk("post_rst_no_done", a_dones - d0, 0);
    a_din = 16'h0009; a_start = 1;
    qa.push_back(8'h30); qa.push_back(8'h30); qa.push_back(8'h30);
    qa.push_back(8'h39); qa.push_back(8'h0D); qa.push_back(8'h0A);
    wait_done_a("post_rst_done_cycle", 7);
    chk("post_rst_q_empty", qa.size(), 0);
    repeat (2) tick();

    // Back-to-back with START held high, digits only.
    c_din = 16'h1234; c_start = 1;
    for (int m = 0; m < 2; m++) begin
      qc.push_back(8'h31); qc.push_back(8'h32); qc.push_back(8'h33); qc.push_back(8'h34);
    end
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("b2b_valid1", c_valid, 1);
      tick();
    end
    chk("b2b_gap_valid", c_valid, 0);
    chk("b2b_gap_done",  c_done, 1);
    tick();
    c_start = 0;
    chk("b2b_second_valid", c_valid, 1);
    chk("b2b_second_data",  c_data, 8'h31);
    repeat (3) tick();
    chk("b2b_valid9", c_valid, 1);
    tick();
    chk("b2b_done10", c_done, 1);
    tick();
    chk("b2b_idle_busy",  c_busy, 0);
    chk("b2b_idle_valid", c_valid, 0);
    chk("b2b_q_empty", qc.size(), 0);
    chk("b2b_dones", c_dones, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
